// File: rtl/inst_pkg.sv
// Shared constants and types for the instruction feeder and anything that
// decodes the instruction words it delivers.
package inst_pkg;

  localparam int INST_LEN = 220;
  localparam int DATA_W   = 64;

  // Number of stream beats needed to cover one instruction word.
  function automatic int calc_inst_beats(input int inst_len, input int data_w);
    return (inst_len + data_w - 1) / data_w;
  endfunction

  localparam int TYPE_LSB = 0;
  localparam int TYPE_W   = 4;

  typedef enum logic [TYPE_W-1:0] {
    COMPUTE = 4'd0,
    LOAD_W  = 4'd1,
    LOAD_B  = 4'd2,
    LOAD_D  = 4'd3,
    WRITE_D = 4'd4
  } inst_type_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } feeder_state_e;

endpackage

// File: rtl/inst_feeder_if.sv
// Stream input and instruction-queue output of the feeder. The master modport
// is the feeder side; the slave modport is the host/topcontrol side.
interface inst_feeder_if #(
  parameter int INST_LEN = inst_pkg::INST_LEN,
  parameter int DATA_W   = inst_pkg::DATA_W
);
  logic [DATA_W-1:0]   s_data;
  logic                s_valid;
  logic                s_ready;
  logic [INST_LEN-1:0] instruct;
  logic                inst_empty;
  logic                inst_req;

  modport master (
    input  s_data, s_valid, inst_req,
    output s_ready, instruct, inst_empty
  );

  modport slave (
    output s_data, s_valid, inst_req,
    input  s_ready, instruct, inst_empty
  );
endinterface

// File: rtl/inst_fifo.sv
// Single-clock show-ahead FIFO: rd_data always shows the head entry and reads
// as zero while the FIFO is empty.
module inst_fifo #(
  parameter int WIDTH = 220,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; a simultaneous
  // write and read advance both pointers and leave the occupancy alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/inst_feeder.sv
// Packs the DATA_W-bit instruction stream into INST_LEN-bit words, queues them
// for topcontrol and tracks progress of one program run.
module inst_feeder #(
  parameter int INST_LEN = inst_pkg::INST_LEN,
  parameter int DATA_W   = inst_pkg::DATA_W,
  parameter int DEPTH    = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] inst_total,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] inst_cnt,
  inst_feeder_if.master    bus
);
  import inst_pkg::*;

  localparam int INST_BEATS = calc_inst_beats(INST_LEN, DATA_W);
  localparam int BEAT_W     = (INST_BEATS > 1) ? $clog2(INST_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(INST_BEATS - 1);

  feeder_state_e       state;
  logic [CNT_W-1:0]    total_q;
  logic [CNT_W-1:0]    recv_cnt;
  logic [BEAT_W-1:0]   beat;
  logic [INST_LEN-1:0] asm_q;
  logic [INST_LEN-1:0] asm_next;
  logic                req_q;
  logic                last_beat;
  logic                accept;
  logic                wr_en;
  logic                pop;
  logic                fifo_empty;
  logic                fifo_full;
  logic [INST_LEN-1:0] fifo_head;

  assign last_beat = (beat == LAST_BEAT);

  // Only the closing beat needs FIFO room; a same-cycle pop does not free it.
  assign bus.s_ready = (state == ST_RUN) && (recv_cnt < total_q) &&
                       (!last_beat || !fifo_full);
  assign accept      = bus.s_valid && bus.s_ready;
  assign wr_en       = accept && last_beat;
  assign pop         = bus.inst_req && !req_q && !fifo_empty;

  assign bus.instruct   = fifo_head;
  assign bus.inst_empty = fifo_empty;

  // Drop the current beat into its slot; bits past INST_LEN are discarded.
  always_comb begin
    asm_next = asm_q;
    for (int k = 0; k < INST_BEATS; k++) begin
      if (beat == BEAT_W'(k)) begin
        for (int b = 0; b < DATA_W; b++) begin
          if (k * DATA_W + b < INST_LEN) begin
            asm_next[k*DATA_W + b] = bus.s_data[b];
          end
        end
      end
    end
  end

  inst_fifo #(
    .WIDTH (INST_LEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (asm_next),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      total_q  <= '0;
      recv_cnt <= '0;
      inst_cnt <= '0;
      beat     <= '0;
      asm_q    <= '0;
      req_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      req_q <= bus.inst_req;
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            total_q  <= inst_total;
            inst_cnt <= '0;
            recv_cnt <= '0;
            beat     <= '0;
            asm_q    <= '0;
            // An empty program completes immediately without entering RUN.
            if (inst_total == '0) begin
              done <= 1'b1;
            end else begin
              state <= ST_RUN;
              busy  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (last_beat) begin
              beat     <= '0;
              asm_q    <= '0;
              recv_cnt <= recv_cnt + CNT_W'(1);
            end else begin
              beat  <= beat + BEAT_W'(1);
              asm_q <= asm_next;
            end
          end
          if (pop) begin
            inst_cnt <= inst_cnt + CNT_W'(1);
            if (inst_cnt + CNT_W'(1) == total_q) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_feeder.sv
// Directed bench for inst_feeder: packing order, FIFO back-pressure, edge-
// triggered pops, empty runs, concurrent push/pop and asynchronous reset.
module tb_inst_feeder;
  import inst_pkg::*;

  localparam int LEN   = 220;
  localparam int DW    = 64;
  localparam int DEPTH = 8;
  localparam int CW    = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] inst_total;
  logic          busy;
  logic          done;
  logic [CW-1:0] inst_cnt;
  int            check_cnt = 0;
  int            pass_cnt  = 0;

  inst_feeder_if #(.INST_LEN(LEN), .DATA_W(DW)) bus ();

  inst_feeder #(
    .INST_LEN (LEN),
    .DATA_W   (DW),
    .DEPTH    (DEPTH),
    .CNT_W    (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .inst_total (inst_total),
    .busy       (busy),
    .done       (done),
    .inst_cnt   (inst_cnt),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation did not finish");
  end

  function automatic logic [63:0] beat_val(input int idx, input int k, input logic [3:0] typ);
    return {16'(idx), 16'(k + 1), 28'(idx * 7919 + k * 104729 + 12345), typ};
  endfunction

  // Reference packing: beat k at bits [k*64 +: 64], everything at or above LEN cleared.
  function automatic logic [255:0] exp_word(input int idx, input logic [3:0] typ);
    logic [255:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) w[k*64 +: 64] = beat_val(idx, k, typ);
    for (int b = LEN; b < 256; b++) w[b] = 1'b0;
    return w;
  endfunction

  function automatic logic [3:0] typ_of(input int idx);
    return 4'(idx % 5);
  endfunction

  task automatic check_output(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic apply_stimulus(input logic [CW-1:0] total);
    inst_total = total;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d, input int budget, output bit ok);
    ok          = 1'b0;
    bus.s_data  = d;
    bus.s_valid = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (bus.s_ready) ok = 1'b1;
      @(negedge clk);
      if (ok) break;
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic send_inst(input int idx, input logic [3:0] typ);
    bit ok;
    for (int k = 0; k < 4; k++) begin
      send_beat(beat_val(idx, k, typ), 40, ok);
      check_output("beat_accept", ok, 1'b1);
    end
  endtask

  task automatic wait_not_empty(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!bus.inst_empty) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_pop(output logic d, output logic [CW-1:0] c);
    bus.inst_req = 1'b1;
    @(negedge clk);
    d = done;
    c = inst_cnt;
    bus.inst_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic          d;
    logic [CW-1:0] c;
    bit            ok;
    logic [3:0]    t1_typ [3];

    t1_typ[0] = LOAD_W;
    t1_typ[1] = LOAD_D;
    t1_typ[2] = COMPUTE;

    rst_n        = 1'b0;
    start        = 1'b0;
    inst_total   = '0;
    bus.s_data   = '0;
    bus.s_valid  = 1'b0;
    bus.inst_req = 1'b0;
    repeat (2) @(negedge clk);
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_done", done, 1'b0);
    check_output("rst_cnt", inst_cnt, 0);
    check_output("rst_ready", bus.s_ready, 1'b0);
    check_output("rst_empty", bus.inst_empty, 1'b1);
    check_output("rst_instruct", bus.instruct, 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] packing and ordering, 3 instructions");
    apply_stimulus(16'd3);
    check_output("t1_busy", busy, 1'b1);
    check_output("t1_ready", bus.s_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      send_beat(beat_val(0, k, t1_typ[0]), 40, ok);
      check_output("t1_beat", ok, 1'b1);
    end
    check_output("t1_empty_before_last", bus.inst_empty, 1'b1);
    send_beat(beat_val(0, 3, t1_typ[0]), 40, ok);
    check_output("t1_beat", ok, 1'b1);
    check_output("t1_empty_t_plus_1", bus.inst_empty, 1'b0);
    send_inst(1, t1_typ[1]);
    send_inst(2, t1_typ[2]);
    for (int i = 0; i < 3; i++) begin
      wait_not_empty(40, ok);
      check_output("t1_wait", ok, 1'b1);
      check_output("t1_word", bus.instruct, exp_word(i, t1_typ[i]));
      check_output("t1_type", bus.instruct[3:0], t1_typ[i]);
      do_pop(d, c);
      check_output("t1_cnt", c, i + 1);
      check_output("t1_done", d, (i == 2));
    end
    check_output("t1_busy_after", busy, 1'b0);
    check_output("t1_done_after", done, 1'b0);

    $display("[TB] full FIFO back-pressure, total 10");
    apply_stimulus(16'd10);
    for (int i = 0; i < 8; i++) send_inst(i, typ_of(i));
    for (int k = 0; k < 3; k++) begin
      send_beat(beat_val(8, k, typ_of(8)), 40, ok);
      check_output("t2_beat", ok, 1'b1);
    end
    bus.s_data  = beat_val(8, 3, typ_of(8));
    bus.s_valid = 1'b1;
    check_output("t2_stall", bus.s_ready, 1'b0);
    @(negedge clk);
    check_output("t2_stall_hold", bus.s_ready, 1'b0);
    check_output("t2_head", bus.instruct, exp_word(0, typ_of(0)));
    bus.inst_req = 1'b1;
    @(negedge clk);
    bus.inst_req = 1'b0;
    check_output("t2_cnt_pop", inst_cnt, 1);
    check_output("t2_ready_after_pop", bus.s_ready, 1'b1);
    @(negedge clk);
    bus.s_valid = 1'b0;
    for (int i = 1; i < 9; i++) begin
      wait_not_empty(40, ok);
      check_output("t2_wait", ok, 1'b1);
      check_output("t2_word", bus.instruct, exp_word(i, typ_of(i)));
      do_pop(d, c);
      check_output("t2_cnt", c, i + 1);
    end
    check_output("t2_drained", bus.inst_empty, 1'b1);
    send_inst(9, typ_of(9));
    wait_not_empty(40, ok);
    check_output("t2_word9", bus.instruct, exp_word(9, typ_of(9)));
    do_pop(d, c);
    check_output("t2_done", d, 1'b1);
    check_output("t2_cnt10", c, 10);

    $display("[TB] held inst_req");
    apply_stimulus(16'd2);
    send_inst(20, LOAD_B);
    send_inst(21, WRITE_D);
    bus.inst_req = 1'b1;
    repeat (5) @(negedge clk);
    check_output("t3_hold_cnt", inst_cnt, 1);
    check_output("t3_hold_head", bus.instruct, exp_word(21, WRITE_D));
    bus.inst_req = 1'b0;
    @(negedge clk);
    do_pop(d, c);
    check_output("t3_cnt2", c, 2);
    check_output("t3_done", d, 1'b1);
    apply_stimulus(16'd1);
    bus.inst_req = 1'b1;
    repeat (3) @(negedge clk);
    bus.inst_req = 1'b0;
    @(negedge clk);
    check_output("t3_empty_hold_cnt", inst_cnt, 0);
    check_output("t3_empty_hold_busy", busy, 1'b1);
    send_inst(22, LOAD_W);
    wait_not_empty(40, ok);
    check_output("t3_word", bus.instruct, exp_word(22, LOAD_W));
    do_pop(d, c);
    check_output("t3_cnt1", c, 1);
    check_output("t3_done1", d, 1'b1);

    $display("[TB] empty program and ignored restart");
    apply_stimulus(16'd0);
    check_output("t4_done", done, 1'b1);
    check_output("t4_busy", busy, 1'b0);
    check_output("t4_ready", bus.s_ready, 1'b0);
    @(negedge clk);
    check_output("t4_done_clear", done, 1'b0);
    check_output("t4_busy_stay", busy, 1'b0);
    apply_stimulus(16'd2);
    apply_stimulus(16'd5);
    send_inst(30, COMPUTE);
    send_inst(31, LOAD_D);
    check_output("t4_ready_total_reached", bus.s_ready, 1'b0);
    check_output("t4_busy_run", busy, 1'b1);
    for (int i = 0; i < 2; i++) begin
      wait_not_empty(40, ok);
      check_output("t4_word", bus.instruct, exp_word(30 + i, (i == 0) ? COMPUTE : LOAD_D));
      do_pop(d, c);
      check_output("t4_done_pop", d, (i == 1));
    end
    check_output("t4_busy_end", busy, 1'b0);

    $display("[TB] concurrent push and pop, 100 instructions");
    apply_stimulus(16'd100);
    fork
      begin
        bit okp;
        for (int i = 0; i < 100; i++) begin
          for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 1)) @(negedge clk);
            send_beat(beat_val(100 + i, k, typ_of(i)), 200, okp);
            if (!okp) check_output("t5_beat_timeout", okp, 1'b1);
          end
        end
      end
      begin
        bit            okc;
        logic          dc;
        logic [CW-1:0] cc;
        for (int p = 0; p < 100; p++) begin
          wait_not_empty(400, okc);
          check_output("t5_wait", okc, 1'b1);
          check_output("t5_word", bus.instruct, exp_word(100 + p, typ_of(p)));
          do_pop(dc, cc);
          check_output("t5_cnt", cc, p + 1);
          if (p == 99) check_output("t5_done", dc, 1'b1);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
    join
    check_output("t5_busy_end", busy, 1'b0);
    check_output("t5_empty_end", bus.inst_empty, 1'b1);

    $display("[TB] asynchronous reset mid-instruction");
    apply_stimulus(16'd2);
    send_inst(40, LOAD_W);
    for (int k = 0; k < 2; k++) begin
      send_beat(beat_val(41, k, LOAD_B), 40, ok);
      check_output("t6_beat", ok, 1'b1);
    end
    check_output("t6_queued", bus.inst_empty, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("t6_busy", busy, 1'b0);
    check_output("t6_done", done, 1'b0);
    check_output("t6_cnt", inst_cnt, 0);
    check_output("t6_ready", bus.s_ready, 1'b0);
    check_output("t6_empty", bus.inst_empty, 1'b1);
    check_output("t6_instruct", bus.instruct, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apply_stimulus(16'd1);
    send_inst(42, WRITE_D);
    wait_not_empty(40, ok);
    check_output("t6_word_after", bus.instruct, exp_word(42, WRITE_D));
    do_pop(d, c);
    check_output("t6_done_after", d, 1'b1);
    check_output("t6_cnt_after", c, 1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
